// File: rtl/sw_seq_driver.sv
// Host-loaded sequence driver for the Smith-Waterman scorer: streams ref/query, waits for finish, reports results.
// Optional expected-result compare is enabled with `define SW_DRV_CHECK_EN.
module sw_seq_driver #(
  parameter int LEN_REF         = 64,
  parameter int LEN_QUERY       = 48,
  parameter int WIDTH_SCORE     = 8,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6,
  parameter int TIMEOUT         = 8191
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [WIDTH_POS_REF-1:0]   wr_addr,
  input  logic [1:0]                 wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [WIDTH_SCORE-1:0]     res_max,
  output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
  output logic [WIDTH_POS_QUERY-1:0] res_pos_query,
  output logic                       pass,
  input  logic [WIDTH_SCORE-1:0]     exp_max,
  input  logic [WIDTH_POS_REF-1:0]   exp_pos_ref,
  input  logic [WIDTH_POS_QUERY-1:0] exp_pos_query,
  output logic                       sw_valid,
  output logic [1:0]                 sw_data_ref,
  output logic [1:0]                 sw_data_query,
  input  logic                       sw_finish,
  input  logic [WIDTH_SCORE-1:0]     sw_max,
  input  logic [WIDTH_POS_REF-1:0]   sw_pos_ref,
  input  logic [WIDTH_POS_QUERY-1:0] sw_pos_query,
  output logic [1:0]                 dbg_state
);

  // Scorer handshake: sw_valid is high for LEN_REF consecutive cycles, one symbol pair per
  // cycle, no backpressure; sw_finish is a single-cycle pulse honoured only while waiting.

  localparam int IW = $clog2(LEN_REF);
  localparam int QW = (LEN_QUERY > 1) ? $clog2(LEN_QUERY) : 1;
  localparam logic [WIDTH_POS_REF-1:0] REF_LIM  = WIDTH_POS_REF'(LEN_REF);
  localparam logic [WIDTH_POS_REF-1:0] QRY_LIM  = WIDTH_POS_REF'(LEN_QUERY);
  localparam logic [IW-1:0]            LAST_IDX = IW'(LEN_REF - 1);
  localparam logic [IW:0]              QRY_CMP  = (IW+1)'(LEN_QUERY);
  localparam logic [15:0]              TO_LIM   = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        go, send_last, fin_hit, to_hit, wr_ok;
  logic [IW-1:0] idx, idx_nxt;
  logic [15:0] wcnt;
  logic [1:0]  ref_buf [LEN_REF];
  logic [1:0]  qry_buf [LEN_QUERY];

  assign dbg_state = state;
  assign idx_nxt   = idx + IW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    send_last = 1'b0;
    fin_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        go        = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: if (idx == LAST_IDX) begin
        send_last = 1'b1;
        state_nxt = S_WAIT;
      end
      // finish takes priority over a coincident timeout
      S_WAIT: if (sw_finish) begin
        fin_hit   = 1'b1;
        state_nxt = S_DONE;
      end else if (wcnt == TO_LIM) begin
        to_hit    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    wr_ok = (state == S_IDLE) && wr_en && !start;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx           <= '0;
      wcnt          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      res_max       <= '0;
      res_pos_ref   <= '0;
      res_pos_query <= '0;
      sw_valid      <= 1'b0;
      sw_data_ref   <= 2'b00;
      sw_data_query <= 2'b00;
      for (int i = 0; i < LEN_REF; i++)   ref_buf[i] <= 2'b00;
      for (int i = 0; i < LEN_QUERY; i++) qry_buf[i] <= 2'b00;
    end else begin
      done <= 1'b0;
      if (wr_ok) begin
        if (!wr_sel && wr_addr < REF_LIM) ref_buf[wr_addr[IW-1:0]] <= wr_data;
        if (wr_sel && wr_addr < QRY_LIM)  qry_buf[wr_addr[QW-1:0]] <= wr_data;
      end
      if (go) begin
        idx           <= '0;
        busy          <= 1'b1;
        timeout       <= 1'b0;
        res_max       <= '0;
        res_pos_ref   <= '0;
        res_pos_query <= '0;
        sw_valid      <= 1'b1;
        sw_data_ref   <= ref_buf[0];
        sw_data_query <= qry_buf[0];
      end
      if (state == S_SEND) begin
        if (send_last) begin
          idx           <= '0;
          wcnt          <= '0;
          sw_valid      <= 1'b0;
          sw_data_ref   <= 2'b00;
          sw_data_query <= 2'b00;
        end else begin
          idx           <= idx_nxt;
          sw_data_ref   <= ref_buf[idx_nxt];
          sw_data_query <= ({1'b0, idx_nxt} < QRY_CMP) ? qry_buf[idx_nxt[QW-1:0]] : 2'b00;
        end
      end
      if (state == S_WAIT) begin
        wcnt <= wcnt + 16'd1;
        if (fin_hit) begin
          res_max       <= sw_max;
          res_pos_ref   <= sw_pos_ref;
          res_pos_query <= sw_pos_query;
        end
        if (to_hit) timeout <= 1'b1;
        if (fin_hit || to_hit) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

`ifdef SW_DRV_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    pass <= 1'b0;
    else if (go)     pass <= 1'b0;
    else if (fin_hit) pass <= (sw_max == exp_max) && (sw_pos_ref == exp_pos_ref) &&
                              (sw_pos_query == exp_pos_query);
    else if (to_hit) pass <= 1'b0;
  end
`else
  logic unused_exp;
  assign unused_exp = ^{exp_max, exp_pos_ref, exp_pos_query};
  assign pass = 1'b0;
`endif

endmodule

// File: doc/sw_seq_driver.md
Name: sw_seq_driver

Overview:
- Transmit-side companion of the Smith-Waterman scoring core.
- Holds one reference sequence and one query sequence written by a host, then streams them into the scorer's serial valid/data_ref/data_query input.
- Waits for the scorer's finish pulse, captures max, pos_ref and pos_query, and reports them to the host with a done pulse.
- Sits between the host/test controller and the scorer.

Parameters:
- LEN_REF, 64, reference length in symbols.
- LEN_QUERY, 48, query length in symbols (must be ≤ LEN_REF).
- WIDTH_SCORE, 8, score width.
- WIDTH_POS_REF, 7, reference position width; also the host write address width.
- WIDTH_POS_QUERY, 6, query position width.
- TIMEOUT, 8191, maximum WAIT cycles before abort (16-bit counter).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  host buffer write strobe.
- wr_sel  in  1  0 = reference buffer, 1 = query buffer.
- wr_addr  in  WIDTH_POS_REF  symbol index, 0-based.
- wr_data  in  2  symbol.
- start  in  1  launch request.
- busy  out  1  high in SEND and WAIT.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  last run aborted; held until next accepted start.
- res_max  out  WIDTH_SCORE  captured max.
- res_pos_ref  out  WIDTH_POS_REF  captured reference position.
- res_pos_query  out  WIDTH_POS_QUERY  captured query position.
- pass  out  1  expected-result compare (optional feature).
- exp_max  in  WIDTH_SCORE  expected max (optional feature).
- exp_pos_ref  in  WIDTH_POS_REF  expected reference position (optional feature).
- exp_pos_query  in  WIDTH_POS_QUERY  expected query position (optional feature).
- sw_valid  out  1  to scorer valid.
- sw_data_ref  out  2  to scorer data_ref.
- sw_data_query  out  2  to scorer data_query.
- sw_finish  in  1  from scorer finish.
- sw_max  in  WIDTH_SCORE  from scorer max.
- sw_pos_ref  in  WIDTH_POS_REF  from scorer pos_ref.
- sw_pos_query  in  WIDTH_POS_QUERY  from scorer pos_query.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - FSM returns to IDLE.
  - All outputs are 0, and sw_valid drops to 0 without waiting for a clock.
  - Both buffers and all counters clear to 0.
- All outputs are registered.
- Buffer writes:
  - Accepted only in IDLE, and not in a cycle where start is accepted.
  - Written on the clock edge.
  - Reference writes with wr_addr ≥ LEN_REF are dropped; query writes with wr_addr ≥ LEN_QUERY are dropped.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE → SEND:
  - Transition occurs when start is sampled high.
  - Clears timeout, res_*, and pass.
  - start is ignored in every other state.
- SEND:
  - Lasts exactly LEN_REF cycles with sw_valid=1 and no gaps.
  - Index k = 0..LEN_REF-1 advances one per cycle.
  - On cycle k, sw_data_ref = ref_buf[k].
  - sw_data_query = qry_buf[k] while k < LEN_QUERY, else 0.
  - Index 0 is sent first, so it lands at scorer position 1.
  - The first valid cycle is the cycle after start is sampled.
  - After k = LEN_REF-1: sw_valid→0, sw_data_*→0, go to WAIT.
- WAIT:
  - A 16-bit counter increments each cycle.
  - If sw_finish is sampled high: capture sw_max, sw_pos_ref and sw_pos_query into res_*, then go to DONE.
  - If the counter reaches TIMEOUT first: timeout←1, res_* stay 0, go to DONE.
  - If finish and timeout occur in the same cycle, finish wins.
- DONE:
  - done=1 for exactly one cycle, with res_* already valid.
  - Next state is IDLE.
- Result hold: res_* and timeout hold until the next accepted start.
- sw_finish outside WAIT is ignored.
- Back-to-back runs: start may be asserted in the cycle done is high, but it is accepted only once IDLE is reached, i.e. on the next cycle.
- Total latency (no timeout): start edge → done is 1 + LEN_REF + (scorer compute cycles) + 1.

Optional Feature:
- Macro: SW_DRV_CHECK_EN.
- Defined:
  - In DONE, pass=1 iff timeout=0 and all three captured values equal the exp_* inputs sampled in the WAIT→DONE cycle.
  - pass holds until the next accepted start.
- Undefined:
  - pass is tied to 0, exp_* are ignored, and no compare logic is built.

Test Plan:
- Reset: pulse reset_n low mid-SEND (k=20) → sw_valid 0 immediately; after release, busy=0, done=0, res_*=0, and the buffers read back as zeros on the next run.
- Ordering:
  - Stimulus: ref[k]=k%4, qry[k]=(k+1)%4, then start.
  - sw_valid is high for exactly 64 cycles.
  - sw_data_ref shows 0,1,2,3,0… over 64 cycles.
  - sw_data_query shows 1,2,3,0… for 48 cycles, then 0 for 16.
- Capture:
  - Stimulus: scorer model returns finish with max=96, pos_ref=64, pos_query=48.
  - Response: done pulses one cycle later with res_max=96, res_pos_ref=64, res_pos_query=48, busy=0.
  - With SW_DRV_CHECK_EN and exp_*=96/64/48: pass=1. With exp_max=95: pass=0.
- Ignore rules:
  - start asserted during SEND/WAIT → no restart; exactly 64 valid cycles.
  - wr_en to ref[5] during WAIT → next run still sends the old ref[5].
  - wr_addr=70 in IDLE → dropped.
- Timeout: scorer never asserts finish → done pulses TIMEOUT+1 cycles after WAIT entry with timeout=1, res_*=0, pass=0.
- Back-to-back: start held high continuously → second SEND begins 2 cycles after the first done, and timeout and res_* are cleared at that start.
